// File: rtl/datapath_pkg.sv
// Shared definitions for the X/Y/Z/ULA datapath: step codes, opcodes,
// register control codes and the sequencer state encoding.
package datapath_pkg;

  localparam int unsigned STEP_BITS = 4;

  localparam logic [STEP_BITS-1:0] STEP_CLR_ALL   = 4'h0;
  localparam logic [STEP_BITS-1:0] STEP_LD_X      = 4'h1;
  localparam logic [STEP_BITS-1:0] STEP_LD_XY     = 4'h2;
  localparam logic [STEP_BITS-1:0] STEP_CLRX_LDY  = 4'h3;
  localparam logic [STEP_BITS-1:0] STEP_SHR_Y     = 4'h4;
  localparam logic [STEP_BITS-1:0] STEP_CLRXY_LDZ = 4'h5;
  localparam logic [STEP_BITS-1:0] STEP_IDLE      = 4'hF;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_CLR  = 3'd1;
  localparam logic [2:0] OP_LDX  = 3'd2;
  localparam logic [2:0] OP_LDXY = 3'd3;
  localparam logic [2:0] OP_LDY  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_FULL = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    HOLD  = 2'd1,
    LOAD  = 2'd2,
    SHFTR = 2'd3
  } reg_ctrl_e;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StLx,
    StLxy,
    StLy,
    StShift,
    StStz,
    StDone
  } seq_state_e;

  // Step code driven while the FSM sits in a given state.
  function automatic logic [STEP_BITS-1:0] step_of(seq_state_e s);
    logic [STEP_BITS-1:0] code;
    code = STEP_IDLE;
    unique case (s)
      StClr:   code = STEP_CLR_ALL;
      StLx:    code = STEP_LD_X;
      StLxy:   code = STEP_LD_XY;
      StLy:    code = STEP_CLRX_LDY;
      StShift: code = STEP_SHR_Y;
      StStz:   code = STEP_CLRXY_LDZ;
      default: code = STEP_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sequenciador_if.sv
// Command handshake and step/status outputs of the step sequencer.
interface sequenciador_if #(
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned STEP_W = 4
);
  logic              start;
  logic [2:0]        opcode;
  logic [CNT_W-1:0]  count;
  logic              ready;
  logic              busy;
  logic [STEP_W-1:0] memoria;
  logic              done;
  logic              err;

  modport master (
    output start, opcode, count,
    input  ready, busy, memoria, done, err
  );

  modport slave (
    input  start, opcode, count,
    output ready, busy, memoria, done, err
  );
endinterface

// File: rtl/contador_desloc.sv
// Loadable saturating down-counter for the shift repeat count.
module contador_desloc #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic [Width-1:0] value_o,
  output logic             last_o,
  output logic             zero_o
);

  logic [Width-1:0] value_q, value_d;

  // Load wins over decrement; decrement stops at zero so the count never wraps.
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (dec_i && (value_q != '0)) begin
      value_d = value_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign last_o  = (value_q == Width'(1));
  assign zero_o  = (value_q == '0);

endmodule

// File: rtl/sequenciador.sv
// Step sequencer: accepts one command per start/ready handshake and emits
// the step codes for the register control decoder, one per cycle.
module sequenciador
  import datapath_pkg::*;
#(
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned STEP_W = STEP_BITS
) (
  input  logic           clock,
  input  logic           reset,
  sequenciador_if.slave  bus
);

  seq_state_e        state_q, state_d;
  logic              full_q, full_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic [STEP_W-1:0] memoria_q, memoria_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_last;
  logic             cnt_zero;

  contador_desloc #(
    .Width (CNT_W)
  ) u_contador_desloc (
    .clk_i      (clock),
    .rst_ni     (reset),
    .load_i     (cnt_load),
    .load_val_i (bus.count),
    .dec_i      (cnt_dec),
    .value_o    (cnt_value),
    .last_o     (cnt_last),
    .zero_o     (cnt_zero)
  );

  assign cnt_dec = (state_q == StShift) && (cnt_value != '0);

  always_comb begin
    state_d  = state_q;
    full_d   = full_q;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          cnt_load = 1'b1;
          full_d   = (bus.opcode == OP_FULL);
          case (bus.opcode)
            OP_NOP:          state_d = StDone;
            OP_CLR, OP_FULL: state_d = StClr;
            OP_LDX:          state_d = StLx;
            OP_LDXY:         state_d = StLxy;
            OP_LDY:          state_d = StLy;
            OP_SHR:          state_d = (bus.count == '0) ? StDone : StShift;
            default: begin
              state_d = StDone;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      StClr:   state_d = full_q ? StLx : StDone;
      StLx:    state_d = full_q ? StLxy : StDone;
      StLxy:   state_d = full_q ? StLy : StDone;
      StLy: begin
        if (!full_q) begin
          state_d = StDone;
        end else begin
          state_d = cnt_zero ? StStz : StShift;
        end
      end
      StShift: begin
        // Zero guard only matters if the counter was somehow already drained.
        if (cnt_last || cnt_zero) begin
          state_d = full_q ? StStz : StDone;
        end
      end
      StStz:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so they register alongside it.
  always_comb begin
    ready_d   = (state_d == StIdle);
    done_d    = (state_d == StDone);
    busy_d    = (state_d != StIdle) && (state_d != StDone);
    memoria_d = STEP_W'(step_of(state_d));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      full_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      memoria_q <= STEP_W'(STEP_IDLE);
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      memoria_q <= memoria_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.ready   = ready_q;
  assign bus.busy    = busy_q;
  assign bus.memoria = memoria_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_sequenciador.sv
// Directed self-checking bench for the step sequencer.
module tb_sequenciador;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [3:0] mem_log   [0:31];
  logic       busy_log  [0:31];
  logic       done_log  [0:31];
  logic       err_log   [0:31];
  logic       ready_log [0:31];
  logic [3:0] exp_seq   [0:15];

  sequenciador_if #(.CNT_W(4), .STEP_W(4)) bus ();

  sequenciador #(
    .CNT_W  (4),
    .STEP_W (4)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept edge is the posedge inside this task; inputs are scrambled after it.
  task automatic issue(input logic [2:0] op, input logic [3:0] cnt);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.count  = cnt;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.opcode = 3'd6;
    bus.count  = 4'hF;
  endtask

  // Index 0 is the cycle right after the accept edge.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_log[i]   = bus.memoria;
      busy_log[i]  = bus.busy;
      done_log[i]  = bus.done;
      err_log[i]   = bus.err;
      ready_log[i] = bus.ready;
    end
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.opcode = 3'd0;
    bus.count  = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.ready, bus.busy, bus.memoria, bus.done, bus.err} !== {1'b1, 1'b0, 4'hF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b busy=%b mem=%h done=%b err=%b, want 1 0 F 0 0",
               bus.ready, bus.busy, bus.memoria, bus.done, bus.err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ldx;
    issue(3'd2, 4'd0);
    capture(4);
    checks++;
    if ({mem_log[0], busy_log[0], ready_log[0]} !== {4'h1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ldx_step: got mem=%h busy=%b rdy=%b, want 1 1 0",
               mem_log[0], busy_log[0], ready_log[0]);
    end
    checks++;
    if ({mem_log[1], done_log[1], err_log[1], busy_log[1]} !== {4'hF, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ldx_done: got mem=%h done=%b err=%b busy=%b, want F 1 0 0",
               mem_log[1], done_log[1], err_log[1], busy_log[1]);
    end
    checks++;
    if ({ready_log[2], done_log[2], mem_log[2]} !== {1'b1, 1'b0, 4'hF}) begin
      errors++;
      $display("FAIL ldx_ready: got rdy=%b done=%b mem=%h, want 1 0 F",
               ready_log[2], done_log[2], mem_log[2]);
    end
  endtask

  task automatic test_shr3;
    issue(3'd5, 4'd3);
    capture(5);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_log[i], done_log[i]} !== {4'h4, 1'b0}) begin
        errors++;
        $display("FAIL shr3_shift[%0d]: got mem=%h done=%b, want 4 0", i, mem_log[i], done_log[i]);
      end
    end
    checks++;
    if ({mem_log[3], done_log[3]} !== {4'hF, 1'b1}) begin
      errors++;
      $display("FAIL shr3_done: got mem=%h done=%b, want F 1", mem_log[3], done_log[3]);
    end
    checks++;
    if (ready_log[4] !== 1'b1) begin
      errors++;
      $display("FAIL shr3_ready: got %b, want 1", ready_log[4]);
    end
  endtask

  task automatic test_shr0;
    issue(3'd5, 4'd0);
    capture(2);
    checks++;
    if ({mem_log[0], busy_log[0], done_log[0], err_log[0]} !== {4'hF, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL shr0_done: got mem=%h busy=%b done=%b err=%b, want F 0 1 0",
               mem_log[0], busy_log[0], done_log[0], err_log[0]);
    end
    checks++;
    if ({ready_log[1], mem_log[1]} !== {1'b1, 4'hF}) begin
      errors++;
      $display("FAIL shr0_ready: got rdy=%b mem=%h, want 1 F", ready_log[1], mem_log[1]);
    end
  endtask

  task automatic test_full2;
    exp_seq[0] = 4'h0; exp_seq[1] = 4'h1; exp_seq[2] = 4'h2; exp_seq[3] = 4'h3;
    exp_seq[4] = 4'h4; exp_seq[5] = 4'h4; exp_seq[6] = 4'h5; exp_seq[7] = 4'hF;
    issue(3'd6, 4'd2);
    capture(9);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({mem_log[i], done_log[i]} !== {exp_seq[i], (i == 7)}) begin
        errors++;
        $display("FAIL full2_seq[%0d]: got mem=%h done=%b, want %h %b",
                 i, mem_log[i], done_log[i], exp_seq[i], (i == 7));
      end
    end
    checks++;
    if (ready_log[8] !== 1'b1) begin
      errors++;
      $display("FAIL full2_ready: got %b, want 1", ready_log[8]);
    end
  endtask

  task automatic test_start_while_busy;
    exp_seq[0] = 4'h0; exp_seq[1] = 4'h1; exp_seq[2] = 4'h2; exp_seq[3] = 4'h3;
    exp_seq[4] = 4'h4; exp_seq[5] = 4'h5; exp_seq[6] = 4'hF; exp_seq[7] = 4'hF;
    issue(3'd6, 4'd1);
    bus.start  = 1'b1;
    bus.opcode = 3'd1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_log[i]   = bus.memoria;
      done_log[i]  = bus.done;
      ready_log[i] = bus.ready;
      bus.start    = (i < 6);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({mem_log[i], done_log[i]} !== {exp_seq[i], (i == 6)}) begin
        errors++;
        $display("FAIL busy_start_seq[%0d]: got mem=%h done=%b, want %h %b",
                 i, mem_log[i], done_log[i], exp_seq[i], (i == 6));
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.ready, bus.memoria, bus.done} !== {1'b1, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL busy_start_not_queued: got rdy=%b mem=%h done=%b, want 1 F 0",
               bus.ready, bus.memoria, bus.done);
    end
  endtask

  task automatic test_illegal;
    issue(3'd7, 4'd3);
    capture(2);
    checks++;
    if ({mem_log[0], busy_log[0], done_log[0], err_log[0], ready_log[0]} !==
        {4'hF, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL illegal_done_err: got mem=%h busy=%b done=%b err=%b rdy=%b, want F 0 1 1 0",
               mem_log[0], busy_log[0], done_log[0], err_log[0], ready_log[0]);
    end
    checks++;
    if ({err_log[1], done_log[1], ready_log[1]} !== {1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL illegal_pulse: got err=%b done=%b rdy=%b, want 0 0 1",
               err_log[1], done_log[1], ready_log[1]);
    end
  endtask

  task automatic test_max_count;
    issue(3'd5, 4'd15);
    capture(17);
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (mem_log[i] !== 4'h4) begin
        errors++;
        $display("FAIL max_shift[%0d]: got mem=%h, want 4", i, mem_log[i]);
      end
    end
    checks++;
    if ({mem_log[15], done_log[15], ready_log[16]} !== {4'hF, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL max_done: got mem=%h done=%b rdy=%b, want F 1 1",
               mem_log[15], done_log[15], ready_log[16]);
    end
  endtask

  task automatic test_reset_mid;
    issue(3'd5, 4'd10);
    capture(3);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.memoria, bus.busy, bus.ready, bus.done} !== {4'hF, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_async: got mem=%h busy=%b rdy=%b done=%b, want F 0 1 0",
               bus.memoria, bus.busy, bus.ready, bus.done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    capture(12);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({done_log[i], mem_log[i], ready_log[i]} !== {1'b0, 4'hF, 1'b1}) begin
        errors++;
        $display("FAIL reset_mid_no_done[%0d]: got done=%b mem=%h rdy=%b, want 0 F 1",
                 i, done_log[i], mem_log[i], ready_log[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    issue(3'd1, 4'd0);
    capture(3);
    checks++;
    if ({mem_log[0], done_log[1], ready_log[2]} !== {4'h0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_clr: got mem=%h done=%b rdy=%b, want 0 1 1",
               mem_log[0], done_log[1], ready_log[2]);
    end
    issue(3'd4, 4'd0);
    capture(2);
    checks++;
    if ({mem_log[0], busy_log[0], done_log[1]} !== {4'h3, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_ldy: got mem=%h busy=%b done=%b, want 3 1 1",
               mem_log[0], busy_log[0], done_log[1]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ldx();
    test_shr3();
    test_shr0();
    test_full2();
    test_start_while_busy();
    test_illegal();
    test_max_count();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
